// File: rtl/storage_access_arbiter_if.sv
// rtl/storage_access_arbiter_if.sv - client/storage bus of the storage access arbiter
interface storage_access_arbiter_if #(
  parameter int N_CH   = 3,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic [N_CH-1:0]        w_ch_en;
  logic [N_CH-1:0]        w_wr_allow;
  logic [N_CH-1:0]        w_req;
  logic [N_CH-1:0]        w_we;
  logic [N_CH*ADDR_W-1:0] w_addr;
  logic [N_CH*DATA_W-1:0] w_wdata;
  logic [N_CH-1:0]        w_gnt;
  logic [N_CH-1:0]        w_rd_valid;
  logic [DATA_W-1:0]      w_rd_data;
  logic                   w_wr_err;
  logic [7:0]             w_err_cnt;
  logic [ADDR_W-1:0]      w_mem_addr;
  logic [DATA_W-1:0]      w_mem_wdata;
  logic                   w_mem_we;
  logic                   w_mem_re;
  logic [DATA_W-1:0]      w_mem_rdata;

  modport master (
    output w_ch_en, w_wr_allow, w_req, w_we, w_addr, w_wdata, w_mem_rdata,
    input  w_gnt, w_rd_valid, w_rd_data, w_wr_err, w_err_cnt,
           w_mem_addr, w_mem_wdata, w_mem_we, w_mem_re
  );

  modport slave (
    input  w_ch_en, w_wr_allow, w_req, w_we, w_addr, w_wdata, w_mem_rdata,
    output w_gnt, w_rd_valid, w_rd_data, w_wr_err, w_err_cnt,
           w_mem_addr, w_mem_wdata, w_mem_we, w_mem_re
  );
endinterface

// File: rtl/storage_access_arbiter.sv
// rtl/storage_access_arbiter.sv - round-robin sharing of the single storage port
// among N_CH clients, with tagged read-return routing.
module storage_access_arbiter #(
  parameter int N_CH   = 3,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input logic                      clk,
  input logic                      rst,
  storage_access_arbiter_if.slave  bus
);
  localparam int PTR_W = $clog2(N_CH);

  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [N_CH-1:0]   elig;
  logic [N_CH-1:0]   gnt;
  logic              win_vld;
  logic              accept;
  logic [PTR_W-1:0]  win_idx;
  logic [PTR_W-1:0]  cand_idx;
  int                cand;
  logic              sel_we;
  logic              sel_allow;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  logic              mem_we_q, mem_re_q, wr_err_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [7:0]        err_cnt_q;
  logic [N_CH-1:0]   rd_valid_q;
  logic              tag_vld_q [RD_LAT];
  logic [PTR_W-1:0]  tag_ch_q  [RD_LAT];

  // Scan from the farthest offset down so the lowest offset from ptr is the last to win.
  always_comb begin
    elig      = bus.w_req & bus.w_ch_en;
    win_vld   = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    sel_we    = 1'b0;
    sel_allow = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int off = N_CH - 1; off >= 0; off--) begin
      cand = int'(ptr_q) + off;
      if (cand >= N_CH) cand = cand - N_CH;
      cand_idx = PTR_W'(cand);
      if (elig[cand_idx]) begin
        win_vld   = 1'b1;
        win_idx   = cand_idx;
        sel_we    = bus.w_we[cand_idx];
        sel_allow = bus.w_wr_allow[cand_idx];
        sel_addr  = bus.w_addr[cand*ADDR_W +: ADDR_W];
        sel_wdata = bus.w_wdata[cand*DATA_W +: DATA_W];
      end
    end
    accept = win_vld & ~rst;
    gnt    = '0;
    if (accept) gnt[win_idx] = 1'b1;
    ptr_d  = (win_idx == PTR_W'(N_CH - 1)) ? '0 : win_idx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      wr_err_q    <= 1'b0;
      err_cnt_q   <= '0;
      rd_valid_q  <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        tag_vld_q[i] <= 1'b0;
        tag_ch_q[i]  <= '0;
      end
    end else begin
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      wr_err_q    <= 1'b0;
      if (win_vld) begin
        ptr_q <= ptr_d;
        if (!sel_we) begin
          mem_re_q   <= 1'b1;
          mem_addr_q <= sel_addr;
        end else if (sel_allow) begin
          mem_we_q    <= 1'b1;
          mem_addr_q  <= sel_addr;
          mem_wdata_q <= sel_wdata;
        end else begin
          // Blocked writes are still granted so the client never stalls on them.
          wr_err_q <= 1'b1;
          if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
        end
      end
      tag_vld_q[0] <= win_vld & ~sel_we;
      tag_ch_q[0]  <= win_idx;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_ch_q[i]  <= tag_ch_q[i-1];
      end
      rd_valid_q <= tag_vld_q[RD_LAT-1] ? (N_CH'(1) << tag_ch_q[RD_LAT-1]) : '0;
    end
  end

  assign bus.w_gnt       = gnt;
  assign bus.w_rd_valid  = rd_valid_q;
  assign bus.w_rd_data   = bus.w_mem_rdata;
  assign bus.w_wr_err    = wr_err_q;
  assign bus.w_err_cnt   = err_cnt_q;
  assign bus.w_mem_addr  = mem_addr_q;
  assign bus.w_mem_wdata = mem_wdata_q;
  assign bus.w_mem_we    = mem_we_q;
  assign bus.w_mem_re    = mem_re_q;
endmodule
